// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit frame per start request, MSB first,
// SCLK derived from a half-period counter in the system clock domain.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV    = 10
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  half_cnt_q, half_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q;
  logic              busy_q, done_q, sclk_q, mosi_q, cs_n_q;
  logic              phase_end;

  always_comb begin
    phase_end  = (half_cnt_q == HALF_LAST);
    half_cnt_d = phase_end ? '0 : half_cnt_q + 1'b1;
    tx_sh_d    = tx_sh_q << 1;
    rx_sh_d    = (rx_sh_q << 1) | DATA_W'(miso);
  end

  // Shifters are pure data and are fully overwritten before being published.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          half_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (start) begin
            tx_sh_q <= tx_data;
            mosi_q  <= tx_data[DATA_W-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          half_cnt_q <= half_cnt_d;
          if (phase_end) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= rx_sh_d;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          half_cnt_q <= half_cnt_d;
          if (phase_end) begin
            sclk_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q != BIT_LAST) begin
              tx_sh_q <= tx_sh_d;
              mosi_q  <= tx_sh_d[DATA_W-1];
            end
            state_q <= LOW;
          end
        end
        LOW: begin
          half_cnt_q <= half_cnt_d;
          if (phase_end) begin
            // After the final bit this LOW phase doubles as the CS hold time.
            if (bit_cnt_q == BITS_ALL) begin
              cs_n_q    <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              rx_data_q <= rx_sh_q;
              mosi_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              sclk_q  <= 1'b1;
              rx_sh_q <= rx_sh_d;
              state_q <= HIGH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
